mix_cols_seq: RTL

Forward AES MixColumns engine for the encrypt datapath; it is the counterpart of the combinational inverse MixColumns column block used on decrypt. It accepts a full 128-bit state over a valid/ready handshake and transforms one 32-bit column per clock using a single shared column datapath. It holds the result until downstream accepts it. A per-block bypass flag lets the final AES round skip MixColumns through the same path, so round latency stays constant.

---
 rtl/mix_cols_seq.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mix_cols_seq.sv
// mix_cols_seq: forward AES MixColumns engine for the encrypt datapath.
// It accepts a 128-bit state block over a valid/ready handshake. It
// transforms one 32-bit column per clock through a single shared column
// datapath. It then holds the result until downstream takes it.
// A per-block bypass flag sends the final round through the same four
// cycles, which keeps the round latency constant.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   upstream presents a block on in_state / in_bypass
//   in_ready   block can be accepted this cycle (FSM state and out_ready only)
//   in_state   128-bit state; column c at [127-32c -: 32], row 0 in the column MSB
//   in_bypass  pass this block through unchanged
//   out_valid  out_state holds a finished block
//   out_ready  downstream accepts out_state this cycle
//   out_state  result block, same packing as in_state
module mix_cols_seq (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t         fsm;
  logic [127:0] state_q;
  logic [1:0]   col;
  logic         bypass;

  logic [31:0]  cur_col;
  logic [31:0]  new_col;

  // Multiply by x in GF(2^8), reduced by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column: the circulant matrix (2 3 1 1).
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    r0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    r1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    r2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    r3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    return {r0, r1, r2, r3};
  endfunction

  // Column select for the shared datapath. Bypass blocks write the column
  // back unchanged, so they take the same number of cycles.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    cur_col = state_q[127:96];
    case (col)
      2'd0: cur_col = state_q[127:96];
      2'd1: cur_col = state_q[95:64];
      2'd2: cur_col = state_q[63:32];
      2'd3: cur_col = state_q[31:0];
      default: cur_col = state_q[127:96];
    endcase
    new_col = bypass ? cur_col : mix_col(cur_col);
  end

  // in_ready never looks at in_valid, so upstream cannot form a loop through it.
  assign in_ready  = (fsm == IDLE) || ((fsm == DONE) && out_ready);
  assign out_valid = (fsm == DONE);
  assign out_state = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm     <= IDLE;
      state_q <= '0;
      col     <= '0;
      bypass  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // register then samples pre-edge values, whatever the statement order.
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            state_q <= in_state;
            bypass  <= in_bypass;
            col     <= 2'd0;
            fsm     <= BUSY;
          end
        end

        BUSY: begin
          case (col)
            2'd0: state_q[127:96] <= new_col;
            2'd1: state_q[95:64]  <= new_col;
            2'd2: state_q[63:32]  <= new_col;
            2'd3: state_q[31:0]   <= new_col;
            default: ;
          endcase
          // col wraps from 3 to 0 on its own, which leaves it ready for the next block.
          col <= col + 2'd1;
          if (col == 2'd3) fsm <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              // The result leaves on this edge and the next block loads in its place.
              state_q <= in_state;
              bypass  <= in_bypass;
              col     <= 2'd0;
              fsm     <= BUSY;
            end else begin
              fsm <= IDLE;
            end
          end
        end

        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
